// File: rtl/vita49_pkg.sv
// Shared VITA49 definitions: header field layout,
// packet constants and the header word builder.
package vita49_pkg;

  localparam logic [3:0] VITA49_PKT_TYPE_SIG = 4'b0001;

  localparam logic [15:0] VITA49_MAX_PAYLOAD = 16'd32766;
  localparam logic [63:0] VITA49_PAD_WORD    = 64'h0;

  localparam int HDR_STRM_ID_LSB  = 32;
  localparam int HDR_PKT_TYPE_LSB = 28;
  localparam int HDR_C_BIT        = 27;
  localparam int HDR_T_BIT        = 26;
  localparam int HDR_TSI_LSB      = 22;
  localparam int HDR_TSF_LSB      = 20;
  localparam int HDR_PKT_CNT_LSB  = 16;
  localparam int HDR_PKT_SIZE_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD
  } pktz_state_t;

  // c, t, tsi and tsf stay zero: plain signal data only
  function automatic logic [63:0] vita49_hdr(
    input logic [31:0] strm_id,
    input logic [3:0]  ptype,
    input logic [3:0]  cnt,
    input logic [15:0] size
  );
    logic [63:0] h;
    h = '0;
    h[HDR_STRM_ID_LSB +: 32]  = strm_id;
    h[HDR_PKT_TYPE_LSB +: 4]  = ptype;
    h[HDR_PKT_CNT_LSB +: 4]   = cnt;
    h[HDR_PKT_SIZE_LSB +: 16] = size;
    return h;
  endfunction

endpackage

// File: rtl/vita49_axis_oreg.sv
// One-entry registered AXIS output stage.
// Loads only when empty or draining (ld_ok).
module vita49_axis_oreg
  import vita49_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [63:0] d_data,
  input  logic        d_last,
  input  logic [1:0]  d_dest,
  input  logic        m_tready,
  output logic [63:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic [1:0]  m_tdest,
  output logic        ld_ok
);

  assign ld_ok = !m_tvalid | m_tready;

  // hold contents while stalled, replace on ld_ok
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdest  <= '0;
    end else if (ld_ok) begin
      m_tvalid <= ld;
      if (ld) begin
        m_tdata <= d_data;
        m_tlast <= d_last;
        m_tdest <= d_dest;
      end
    end
  end

endmodule

// File: rtl/vita49_packetizer.sv
// Frames a raw 64-bit sample stream into
// VITA49 signal-data packets with padding.
module vita49_packetizer
  import vita49_pkg::*;
#(
  parameter logic [3:0]  PKT_TYPE          = VITA49_PKT_TYPE_SIG,
  parameter logic [15:0] MAX_PAYLOAD_WORDS = VITA49_MAX_PAYLOAD,
  parameter logic [63:0] PAD_WORD          = VITA49_PAD_WORD
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic [63:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TDEST,
  output logic        S_AXIS_TREADY,
  output logic [63:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  output logic [7:0]  M_AXIS_TSTRB,
  output logic [1:0]  M_AXIS_TDEST,
  input  logic        M_AXIS_TREADY,
  input  logic [31:0] cmd,
  input  logic [15:0] pkt_len,
  input  logic [31:0] strmID_0,
  input  logic [31:0] strmID_1,
  output logic [15:0] pad_cnt,
  output logic        cfg_err
);

  pktz_state_t state;
  logic        srst;
  logic        ld_ok;
  logic        ld;
  logic [63:0] d_data;
  logic        d_last;
  logic [1:0]  d_dest;
  logic        sel;
  logic [15:0] n_len;
  logic [15:0] beat_cnt;
  logic [3:0]  pkt_cnt0;
  logic [3:0]  pkt_cnt1;
  logic        last_beat;
  logic        hdr_go;
  logic        s_xfr;
  logic        pad_go;
  logic [3:0]  hdr_cnt;
  logic [31:0] hdr_sid;
  logic [15:0] hdr_size;
  logic        unused_cmd;

  assign unused_cmd = ^cmd[31:2];

  assign srst = AXIS_ARESET | cmd[1];

  assign cfg_err = (pkt_len == 16'd0)
                 | (pkt_len > MAX_PAYLOAD_WORDS);

  assign last_beat = (beat_cnt == n_len - 16'd1);

  assign hdr_go = (state == ST_HDR) & cmd[0]
                & S_AXIS_TVALID & ld_ok
                & !cfg_err & !srst;

  assign S_AXIS_TREADY = (state == ST_PAYLOAD)
                       & ld_ok & !srst;

  assign s_xfr  = S_AXIS_TREADY & S_AXIS_TVALID;
  assign pad_go = (state == ST_PAD) & ld_ok & !srst;

  assign hdr_cnt  = S_AXIS_TDEST ? pkt_cnt1 : pkt_cnt0;
  assign hdr_sid  = S_AXIS_TDEST ? strmID_1 : strmID_0;
  assign hdr_size = {pkt_len[14:0], 1'b0} + 16'd2;

  assign M_AXIS_TSTRB = 8'hff;

  // select the word offered to the output register
  always_comb begin
    ld     = 1'b0;
    d_data = PAD_WORD;
    d_last = 1'b0;
    d_dest = {1'b0, sel};
    unique case (1'b1)
      hdr_go: begin
        ld     = 1'b1;
        d_data = vita49_hdr(hdr_sid, PKT_TYPE,
                            hdr_cnt, hdr_size);
        d_dest = {1'b0, S_AXIS_TDEST};
      end
      s_xfr: begin
        ld     = 1'b1;
        d_data = S_AXIS_TDATA;
        d_last = last_beat;
      end
      pad_go: begin
        ld     = 1'b1;
        d_last = last_beat;
      end
      default: ;
    endcase
  end

  // packet framing FSM and counters
  always_ff @(posedge AXIS_ACLK) begin
    if (srst) begin
      state    <= ST_IDLE;
      sel      <= 1'b0;
      n_len    <= '0;
      beat_cnt <= '0;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
      pad_cnt  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd[0]) state <= ST_HDR;
        end
        ST_HDR: begin
          if (!cmd[0]) begin
            state <= ST_IDLE;
          end else if (hdr_go) begin
            sel      <= S_AXIS_TDEST;
            n_len    <= pkt_len;
            beat_cnt <= '0;
            if (S_AXIS_TDEST) pkt_cnt1 <= pkt_cnt1 + 4'd1;
            else              pkt_cnt0 <= pkt_cnt0 + 4'd1;
            state    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (s_xfr) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (last_beat) begin
              state <= cmd[0] ? ST_HDR : ST_IDLE;
            end else if (S_AXIS_TLAST) begin
              state <= ST_PAD;
              if (pad_cnt != 16'hffff)
                pad_cnt <= pad_cnt + 16'd1;
            end
          end
        end
        ST_PAD: begin
          if (pad_go) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (last_beat)
              state <= cmd[0] ? ST_HDR : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  vita49_axis_oreg u_oreg (
    .clk      (AXIS_ACLK),
    .rst      (srst),
    .ld       (ld),
    .d_data   (d_data),
    .d_last   (d_last),
    .d_dest   (d_dest),
    .m_tready (M_AXIS_TREADY),
    .m_tdata  (M_AXIS_TDATA),
    .m_tvalid (M_AXIS_TVALID),
    .m_tlast  (M_AXIS_TLAST),
    .m_tdest  (M_AXIS_TDEST),
    .ld_ok    (ld_ok)
  );

endmodule

// File: tb/tb_vita49_packetizer.sv
// Directed bench for vita49_packetizer with an
// output scoreboard and stall-stability watch.
module tb_vita49_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tdest = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [7:0]  m_tstrb;
  logic [1:0]  m_tdest;
  logic        m_tready = 1'b1;
  logic [31:0] cmd = '0;
  logic [15:0] pkt_len = 16'd3;
  logic [31:0] sid0 = 32'hA5A5_0001;
  logic [31:0] sid1 = 32'hBEEF_0002;
  logic [15:0] pad_cnt;
  logic        cfg_err;

  int total = 0;
  int bad = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  bit rnd_ready = 1'b0;
  bit ignore = 1'b0;
  logic [74:0] q[$];
  logic        stall_prev = 1'b0;
  logic [66:0] held;

  always #5 clk = ~clk;

  vita49_packetizer dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TDEST  (s_tdest),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TDEST  (m_tdest),
    .M_AXIS_TREADY (m_tready),
    .cmd           (cmd),
    .pkt_len       (pkt_len),
    .strmID_0      (sid0),
    .strmID_1      (sid1),
    .pad_cnt       (pad_cnt),
    .cfg_err       (cfg_err)
  );

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(
    input logic [31:0] sid, input int cnt,
    input int len);
    logic [3:0]  c;
    logic [15:0] sz;
    c  = 4'(cnt);
    sz = 16'(2 * (len + 1));
    return {sid, 4'h1, 8'h00, c, sz};
  endfunction

  task automatic push_pkt(input bit sel, input int len,
                          input logic [63:0] base,
                          input int last_at);
    logic [63:0] d;
    if (sel) begin
      q.push_back({8'hff, 1'b0, 2'b01,
                   mk_hdr(sid1, cnt1 % 16, len)});
      cnt1++;
    end else begin
      q.push_back({8'hff, 1'b0, 2'b00,
                   mk_hdr(sid0, cnt0 % 16, len)});
      cnt0++;
    end
    for (int i = 0; i < len; i++) begin
      d = base + 64'(i);
      if (last_at >= 0 && i > last_at) d = '0;
      q.push_back({8'hff, (i == len - 1),
                   {1'b0, sel}, d});
    end
  endtask

  task automatic send_beats(input int n,
                            input logic [63:0] base,
                            input int last_at);
    for (int i = 0; i < n; i++) begin
      bit done;
      done = 1'b0;
      s_tdata  = base + 64'(i);
      s_tlast  = (i == last_at);
      s_tvalid = 1'b1;
      for (int t = 0; t < 400 && !done; t++) begin
        @(negedge clk);
        if (s_tready) begin
          @(posedge clk);
          #1;
          done = 1'b1;
        end
      end
      if (!done) check("src_timeout", 0, 1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !m_tvalid) done = 1'b1;
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rnd_ready ? 1'($urandom_range(0, 1))
                           : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (stall_prev && m_tvalid)
      check("stall_hold", {m_tlast, m_tdest, m_tdata},
            held);
    stall_prev = m_tvalid && !m_tready;
    held = {m_tlast, m_tdest, m_tdata};
    if (m_tvalid && m_tready && !ignore) begin
      if (q.size() == 0) begin
        check("unexpected_out", {m_tlast, m_tdest, m_tdata},
              128'hx);
      end else begin
        check("out_word",
              {m_tstrb, m_tlast, m_tdest, m_tdata},
              q.pop_front());
      end
    end
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", m_tvalid, 1'b0);
    check("rst_out", {m_tlast, m_tdest, m_tdata}, '0);
    check("rst_pad", pad_cnt, 16'd0);
    check("rst_srdy", s_tready, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    cmd = 32'h1;
    pkt_len = 16'd3;
    s_tdest = 1'b0;
    push_pkt(1'b0, 3, 64'hD000_0000_0000_0000, -1);
    send_beats(3, 64'hD000_0000_0000_0000, -1);
    drain("t1_drain");

    pkt_len = 16'd1;
    s_tdest = 1'b1;
    for (int p = 0; p < 18; p++) begin
      push_pkt(1'b1, 1, 64'hC100_0000_0000_0000 + 64'(p), -1);
      send_beats(1, 64'hC100_0000_0000_0000 + 64'(p), -1);
    end
    drain("t2_drain");

    pkt_len = 16'd4;
    s_tdest = 1'b0;
    push_pkt(1'b0, 4, 64'hE300_0000_0000_0000, 1);
    send_beats(2, 64'hE300_0000_0000_0000, 1);
    drain("t3_drain");
    check("t3_pad_cnt", pad_cnt, 16'd1);

    rnd_ready = 1'b1;
    pkt_len = 16'd8;
    push_pkt(1'b0, 8, 64'hF400_0000_0000_0000, -1);
    send_beats(8, 64'hF400_0000_0000_0000, -1);
    drain("t4_drain");
    rnd_ready = 1'b0;

    pkt_len = 16'd0;
    s_tdata = 64'h5555_0000_0000_0000;
    s_tvalid = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_tvalid) seen++;
    end
    check("t5_err0", cfg_err, 1'b1);
    pkt_len = 16'h7FFF;
    repeat (8) begin
      @(negedge clk);
      if (m_tvalid) seen++;
    end
    check("t5_err7fff", cfg_err, 1'b1);
    check("t5_no_out", seen, 0);
    @(posedge clk);
    #1;
    pkt_len = 16'd2;
    #1;
    check("t5_ok", cfg_err, 1'b0);
    push_pkt(1'b0, 2, 64'h5555_0000_0000_0000, -1);
    send_beats(2, 64'h5555_0000_0000_0000, -1);
    drain("t5_drain");

    ignore = 1'b1;
    pkt_len = 16'd8;
    s_tdata = 64'h6600_0000_0000_0000;
    s_tvalid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cmd = 32'h2;
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check("t6_vld", m_tvalid, 1'b0);
    check("t6_pad", pad_cnt, 16'd0);
    check("t6_srdy", s_tready, 1'b0);
    cmd = 32'h0;
    @(posedge clk);
    #1;
    q.delete();
    ignore = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
    cmd = 32'h1;
    pkt_len = 16'd1;
    push_pkt(1'b0, 1, 64'h7700_0000_0000_0000, -1);
    send_beats(1, 64'h7700_0000_0000_0000, -1);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
